multiplicador: RTL and testbench

MULTIPLICADOR -- requirements
Module: multiplicador

---
 rtl/multiplicador.sv | 133 +++++++++++++
 tb/tb_multiplicador.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/multiplicador.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, LSB first.
// Define MULT_SINAL_EN to add the sinal port and the AJUSTA sign-correction state.
module multiplicador #(
    parameter int LARGURA = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inicio,
`ifdef MULT_SINAL_EN
    input  logic               sinal,
`endif
    input  logic [LARGURA-1:0] operando1,
    input  logic [LARGURA-1:0] operando2,
    output logic [LARGURA-1:0] mulH,
    output logic [LARGURA-1:0] mulL,
    output logic               ocupado,
    output logic               pronto
);

    localparam int CW = $clog2(LARGURA + 1);

`ifdef MULT_SINAL_EN
    typedef enum logic [1:0] {OCIOSO, CALCULA, AJUSTA} estado_t;
`else
    typedef enum logic [0:0] {OCIOSO, CALCULA} estado_t;
`endif

    estado_t                estado, estado_prox;
    logic [LARGURA-1:0]     mcando, mcando_prox;
    logic [LARGURA-1:0]     mdor, mdor_prox;
    logic [2*LARGURA:0]     acc, acc_prox;
    logic [CW-1:0]          cont, cont_prox;
    logic [LARGURA-1:0]     mul_h_prox, mul_l_prox;
    logic                   ocupado_prox, pronto_prox;
    logic [LARGURA:0]       soma;
    logic [2*LARGURA:0]     passo;
`ifdef MULT_SINAL_EN
    logic                   negar, negar_prox;
    logic [2*LARGURA-1:0]   produto;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado  <= OCIOSO;
            mcando  <= '0;
            mdor    <= '0;
            acc     <= '0;
            cont    <= '0;
            mulH    <= '0;
            mulL    <= '0;
            ocupado <= 1'b0;
            pronto  <= 1'b0;
`ifdef MULT_SINAL_EN
            negar   <= 1'b0;
`endif
        end else begin
            estado  <= estado_prox;
            mcando  <= mcando_prox;
            mdor    <= mdor_prox;
            acc     <= acc_prox;
            cont    <= cont_prox;
            mulH    <= mul_h_prox;
            mulL    <= mul_l_prox;
            ocupado <= ocupado_prox;
            pronto  <= pronto_prox;
`ifdef MULT_SINAL_EN
            negar   <= negar_prox;
`endif
        end
    end

    // The upper half keeps one extra bit so the carry of each add survives the shift.
    always_comb begin
        estado_prox  = estado;
        mcando_prox  = mcando;
        mdor_prox    = mdor;
        acc_prox     = acc;
        cont_prox    = cont;
        mul_h_prox   = mulH;
        mul_l_prox   = mulL;
        ocupado_prox = ocupado;
        pronto_prox  = 1'b0;
        soma         = acc[2*LARGURA:LARGURA] + (mdor[0] ? {1'b0, mcando} : '0);
        passo        = {1'b0, soma, acc[LARGURA-1:1]};
`ifdef MULT_SINAL_EN
        negar_prox   = negar;
        produto      = negar ? (~acc[2*LARGURA-1:0] + 1'b1) : acc[2*LARGURA-1:0];
`endif
        case (estado)
            OCIOSO: begin
                if (inicio) begin
`ifdef MULT_SINAL_EN
                    mcando_prox = (sinal && operando1[LARGURA-1]) ? (~operando1 + 1'b1) : operando1;
                    mdor_prox   = (sinal && operando2[LARGURA-1]) ? (~operando2 + 1'b1) : operando2;
                    negar_prox  = sinal && (operando1[LARGURA-1] ^ operando2[LARGURA-1]);
`else
                    mcando_prox = operando1;
                    mdor_prox   = operando2;
`endif
                    acc_prox     = '0;
                    cont_prox    = '0;
                    ocupado_prox = 1'b1;
                    estado_prox  = CALCULA;
                end
            end
            CALCULA: begin
                acc_prox  = passo;
                mdor_prox = mdor >> 1;
                cont_prox = cont + CW'(1);
                if (cont == CW'(LARGURA - 1)) begin
`ifdef MULT_SINAL_EN
                    estado_prox = AJUSTA;
`else
                    {mul_h_prox, mul_l_prox} = passo[2*LARGURA-1:0];
                    pronto_prox  = 1'b1;
                    ocupado_prox = 1'b0;
                    estado_prox  = OCIOSO;
`endif
                end
            end
`ifdef MULT_SINAL_EN
            AJUSTA: begin
                {mul_h_prox, mul_l_prox} = produto;
                pronto_prox  = 1'b1;
                ocupado_prox = 1'b0;
                estado_prox  = OCIOSO;
            end
`endif
            default: estado_prox = OCIOSO;
        endcase
    end

endmodule

// File: tb/tb_multiplicador.sv
// Directed, table-driven bench for multiplicador; covers the signed vectors when MULT_SINAL_EN is defined.
module tb_multiplicador;

    localparam int W = 16;
`ifdef MULT_SINAL_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         inicio;
`ifdef MULT_SINAL_EN
    logic         sinal;
`endif
    logic [W-1:0] operando1, operando2;
    logic [W-1:0] mulH, mulL;
    logic         ocupado, pronto;

    int nvec = 0;
    int nmis = 0;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sg;
        logic [W-1:0] h;
        logic [W-1:0] l;
    } vec_t;

    vec_t vecs[$];

    multiplicador #(.LARGURA(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inicio    (inicio),
`ifdef MULT_SINAL_EN
        .sinal     (sinal),
`endif
        .operando1 (operando1),
        .operando2 (operando2),
        .mulH      (mulH),
        .mulL      (mulL),
        .ocupado   (ocupado),
        .pronto    (pronto)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives a start request, waits for the accepting edge, then scrambles the operands.
    task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
        operando1 = a;
        operando2 = b;
        inicio    = 1'b1;
`ifdef MULT_SINAL_EN
        sinal     = sg;
`endif
        @(posedge clk);
        #1;
        inicio    = 1'b0;
        operando1 = W'($urandom);
        operando2 = W'($urandom);
`ifdef MULT_SINAL_EN
        sinal     = ~sg;
`endif
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (pronto !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;

        vecs.push_back('{"3x5",       16'h0003, 16'h0005, 1'b0, 16'h0000, 16'h000F});
        vecs.push_back('{"FFFFxFFFF", 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 16'h0001});
        vecs.push_back('{"1234x0",    16'h1234, 16'h0000, 1'b0, 16'h0000, 16'h0000});
        vecs.push_back('{"ABCDx1234", 16'hABCD, 16'h1234, 1'b0, 16'h0C37, 16'h4FA4});
        vecs.push_back('{"8000x2",    16'h8000, 16'h0002, 1'b0, 16'h0001, 16'h0000});
        vecs.push_back('{"1xFFFF",    16'h0001, 16'hFFFF, 1'b0, 16'h0000, 16'hFFFF});
        vecs.push_back('{"FFxFF",     16'h00FF, 16'h00FF, 1'b0, 16'h0000, 16'hFE01});
        vecs.push_back('{"FFFDx5u",   16'hFFFD, 16'h0005, 1'b0, 16'h0004, 16'hFFF1});
`ifdef MULT_SINAL_EN
        vecs.push_back('{"FFFDx5s",   16'hFFFD, 16'h0005, 1'b1, 16'hFFFF, 16'hFFF1});
        vecs.push_back('{"8000x8000s",16'h8000, 16'h8000, 1'b1, 16'h4000, 16'h0000});
        vecs.push_back('{"FFFFxFFFFs",16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 16'h0001});
        vecs.push_back('{"FFFDx0s",   16'hFFFD, 16'h0000, 1'b1, 16'h0000, 16'h0000});
        sinal = 1'b0;
`endif

        rst_n     = 1'b0;
        inicio    = 1'b0;
        operando1 = '0;
        operando2 = '0;
        #12;
        check_output("reset result",  {mulH, mulL}, 32'h0);
        check_output("reset ocupado", ocupado, 0);
        check_output("reset pronto",  pronto, 0);

        @(negedge clk);
        rst_n = 1'b1;
        foreach (vecs[i]) begin
            if (i > 0) @(negedge clk);
            apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].sg);
            check_output({vecs[i].name, " ocupado busy"}, ocupado, 1);
            check_output({vecs[i].name, " pronto early"}, pronto, 0);
            wait_result(lat);
            check_output({vecs[i].name, " latency"}, lat, LAT);
            check_output({vecs[i].name, " product"}, {mulH, mulL}, {vecs[i].h, vecs[i].l});
            check_output({vecs[i].name, " ocupado done"}, ocupado, 0);
            @(posedge clk);
            #1;
            check_output({vecs[i].name, " pronto pulse"}, pronto, 0);
            check_output({vecs[i].name, " hold"}, {mulH, mulL}, {vecs[i].h, vecs[i].l});
        end

        // Start request during busy is ignored; start in the pronto cycle is accepted.
        @(negedge clk);
        apply_stimulus(16'h0100, 16'h0100, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        operando1 = 16'h0002;
        operando2 = 16'h0002;
        inicio    = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        check_output("busy ocupado", ocupado, 1);
        wait_result(lat);
        check_output("busy latency", lat + 5, LAT);
        check_output("busy product", {mulH, mulL}, 32'h0001_0000);
        apply_stimulus(16'h0002, 16'h0002, 1'b0);
        check_output("b2b pronto clear", pronto, 0);
        check_output("b2b ocupado", ocupado, 1);
        check_output("b2b hold", {mulH, mulL}, 32'h0001_0000);
        wait_result(lat);
        check_output("b2b latency", lat, LAT);
        check_output("b2b product", {mulH, mulL}, 32'h0000_0004);

        // Reset in the middle of an operation.
        @(negedge clk);
        apply_stimulus(16'h0003, 16'h0005, 1'b0);
        wait_result(lat);
        check_output("pre-reset product", {mulH, mulL}, 32'h0000_000F);
        @(negedge clk);
        apply_stimulus(16'h00FF, 16'h00FF, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("abort result",  {mulH, mulL}, 32'h0);
        check_output("abort ocupado", ocupado, 0);
        check_output("abort pronto",  pronto, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check_output("abort no pronto", pronto, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(16'h0002, 16'h0003, 1'b0);
        check_output("post-reset accept", ocupado, 1);
        wait_result(lat);
        check_output("post-reset latency", lat, LAT);
        check_output("post-reset product", {mulH, mulL}, 32'h0000_0006);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
